piso_serializer_tx: RTL

- Parallel-in, serial-out shift-register transmitter.
- Transmit end of the team's serial bit path: accepts a WIDTH-bit word through a valid/ready load handshake and emits it one bit per enabled clock.
- Framing strobes mark the first and last bit so a downstream serial-in capture register can re-assemble the word.
- Built from plain edge-triggered storage, same style as the team's flip-flop library.

---
 rtl/piso_pkg.sv | 20 ++
 rtl/piso_shift_core.sv | 46 ++++
 rtl/piso_serializer_tx.sv | 152 +++++++++++++++
 3 files changed

// File: rtl/piso_pkg.sv
// Shared definitions for the piso serializer: state encoding and a helper
// that sizes the bit counter for a given word width.
package piso_pkg;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_SHIFT  = 2'd1;
    localparam logic [1:0] ST_PARITY = 2'd2;

    typedef enum logic [1:0] {
        S_IDLE   = ST_IDLE,
        S_SHIFT  = ST_SHIFT,
        S_PARITY = ST_PARITY
    } state_e;

    // Counter must hold WIDTH-1; never narrower than one bit.
    function automatic int cnt_width(input int width);
        return (width <= 2) ? 1 : $clog2(width);
    endfunction

endpackage

// File: rtl/piso_shift_core.sv
// WIDTH-bit shift register with parallel load and logical (zero-fill) shift.
// MSB_FIRST selects the shift direction; next_bit is the bit that becomes the
// head of the register after the next shift.
module piso_shift_core
    import piso_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [WIDTH-1:0] load_data,
    input  logic             shift,
    output logic             next_bit
);

    logic [WIDTH-1:0] data_q;
    logic [WIDTH-1:0] data_d;

    // Load has priority over shift; hold otherwise.
    always_comb begin
        data_d = data_q;
        if (load) begin
            data_d = load_data;
        end else if (shift) begin
            if (MSB_FIRST) begin
                data_d = {data_q[WIDTH-2:0], 1'b0};
            end else begin
                data_d = {1'b0, data_q[WIDTH-1:1]};
            end
        end
    end

    // Register storage with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            data_q <= '0;
        end else begin
            data_q <= data_d;
        end
    end

    assign next_bit = MSB_FIRST ? data_q[WIDTH-2] : data_q[1];

endmodule

// File: rtl/piso_serializer_tx.sv
// Parallel-in serial-out transmitter with valid/ready load and framing strobes.
// Optional even-parity trailer bit is enabled by defining PISO_PARITY_EN.
//
// Handshake: a word is taken on a rising edge where load_valid && load_ready;
// load_ready is high only in IDLE, and load_valid outside IDLE is ignored, so
// upstream holds load_valid (and load_data) until it sees load_ready.
module piso_serializer_tx
    import piso_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] load_data,
    input  logic             load_valid,
    output logic             load_ready,
    input  logic             shift_en,
    output logic             sout,
    output logic             sout_valid,
    output logic             sout_first,
    output logic             sout_last,
    output logic             busy
);

    localparam int             CW       = cnt_width(WIDTH);
    localparam logic [CW-1:0]  CNT_LOAD = CW'(WIDTH - 1);

    state_e        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          sout_q, sout_d;
    logic          sout_valid_q, sout_valid_d;
    logic          sout_first_q, sout_first_d;
    logic          sout_last_q, sout_last_d;
    logic          busy_q, busy_d;
    logic          accept;
    logic          advance;
    logic          first_bit;
    logic          core_next_bit;
`ifdef PISO_PARITY_EN
    logic          parity_q, parity_d;
`endif

    piso_shift_core #(
        .WIDTH     (WIDTH),
        .MSB_FIRST (MSB_FIRST)
    ) u_core (
        .clk       (clk),
        .rst       (rst),
        .load      (accept),
        .load_data (load_data),
        .shift     (advance),
        .next_bit  (core_next_bit)
    );

    // Next-state, counter and registered-output logic for the frame FSM.
    always_comb begin
        accept       = load_valid && (state_q == S_IDLE);
        advance      = shift_en && (state_q == S_SHIFT);
        first_bit    = MSB_FIRST ? load_data[WIDTH-1] : load_data[0];
        state_d      = state_q;
        cnt_d        = cnt_q;
        sout_d       = sout_q;
        sout_first_d = sout_first_q;
`ifdef PISO_PARITY_EN
        parity_d     = accept ? ^load_data : parity_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    state_d      = S_SHIFT;
                    cnt_d        = CNT_LOAD;
                    sout_d       = first_bit;
                    sout_first_d = 1'b1;
                end
            end
            S_SHIFT: begin
                if (shift_en) begin
                    sout_first_d = 1'b0;
                    if (cnt_q == '0) begin
`ifdef PISO_PARITY_EN
                        state_d = S_PARITY;
                        sout_d  = parity_q;
`else
                        state_d = S_IDLE;
                        sout_d  = 1'b0;
`endif
                    end else begin
                        cnt_d  = cnt_q - 1'b1;
                        sout_d = core_next_bit;
                    end
                end
            end
`ifdef PISO_PARITY_EN
            S_PARITY: begin
                if (shift_en) begin
                    state_d = S_IDLE;
                    sout_d  = 1'b0;
                end
            end
`endif
            default: begin
                state_d      = S_IDLE;
                cnt_d        = '0;
                sout_d       = 1'b0;
                sout_first_d = 1'b0;
            end
        endcase
        busy_d       = (state_d != S_IDLE);
        sout_valid_d = busy_d;
`ifdef PISO_PARITY_EN
        sout_last_d  = (state_d == S_PARITY);
`else
        sout_last_d  = (state_d == S_SHIFT) && (cnt_d == '0);
`endif
    end

    // State, counter and output flops; reset abandons any frame in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            cnt_q        <= '0;
            sout_q       <= 1'b0;
            sout_valid_q <= 1'b0;
            sout_first_q <= 1'b0;
            sout_last_q  <= 1'b0;
            busy_q       <= 1'b0;
`ifdef PISO_PARITY_EN
            parity_q     <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            sout_q       <= sout_d;
            sout_valid_q <= sout_valid_d;
            sout_first_q <= sout_first_d;
            sout_last_q  <= sout_last_d;
            busy_q       <= busy_d;
`ifdef PISO_PARITY_EN
            parity_q     <= parity_d;
`endif
        end
    end

    assign load_ready = (state_q == S_IDLE);
    assign sout       = sout_q;
    assign sout_valid = sout_valid_q;
    assign sout_first = sout_first_q;
    assign sout_last  = sout_last_q;
    assign busy       = busy_q;

endmodule
